// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared load/store types, size masks and alignment helpers
// Revision: 1.0
// ============================================================================
package lsu_pkg;

   typedef enum logic [2:0] {
      MEM_B    = 3'b000,
      MEM_H    = 3'b001,
      MEM_W    = 3'b010,
      MEM_BU   = 3'b011,
      MEM_HU   = 3'b100,
      MEM_NONE = 3'b111
   } mem_acc_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   localparam logic [3:0] SIZE_MASK_B = 4'b0001;
   localparam logic [3:0] SIZE_MASK_H = 4'b0011;
   localparam logic [3:0] SIZE_MASK_W = 4'b1111;

   function automatic logic [3:0] size_mask(input mem_acc_mode_e mode);
      case (mode)
         MEM_B, MEM_BU: size_mask = SIZE_MASK_B;
         MEM_H, MEM_HU: size_mask = SIZE_MASK_H;
         MEM_W:         size_mask = SIZE_MASK_W;
         default:       size_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic misaligned(input mem_acc_mode_e mode, input logic [1:0] offset);
      case (mode)
         MEM_H, MEM_HU: misaligned = offset[0];
         MEM_W:         misaligned = (offset != 2'b00);
         default:       misaligned = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane mask/data shifting and load sign/zero extension
// Revision: 1.0
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  mem_acc_mode_e i_mode,
   input  logic [1:0]    i_offset,
   input  logic [31:0]   i_wdata,
   input  logic [31:0]   i_beat_lo,
   input  logic [31:0]   i_beat_hi,
   output logic [7:0]    o_lane_mask,
   output logic [63:0]   o_lane_data,
   output logic          o_split,
   output logic [31:0]   o_load_data
);

   logic [31:0] w_shifted;

   always_comb begin
      o_lane_mask = {4'b0000, size_mask(i_mode)} << i_offset;
      o_lane_data = {32'h0, i_wdata} << {i_offset, 3'b000};
      o_split     = |o_lane_mask[7:4];
      // Only the low word of the realigned beat pair carries the loaded value
      w_shifted   = 32'({i_beat_hi, i_beat_lo} >> {i_offset, 3'b000});
      case (i_mode)
         MEM_B:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         MEM_H:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         MEM_W:   o_load_data = w_shifted;
         MEM_BU:  o_load_data = {24'h0, w_shifted[7:0]};
         MEM_HU:  o_load_data = {16'h0, w_shifted[15:0]};
         default: o_load_data = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_sequencer.sv
`default_nettype none
// ============================================================================
// lsu_sequencer : load/store sequencer issuing one or two aligned bus beats.
// Optional macro MISALIGN_SPLIT_EN: split word-crossing accesses instead of
// rejecting misaligned ones.
// Revision: 1.0
// ============================================================================
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [2:0]        mem_acc_mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   lsu_state_e        state_q, state_d;
   mem_acc_mode_e     mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       beat0_q, beat0_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              merr_q, merr_d;
   logic              berr_q, berr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   mem_acc_mode_e     w_mode;
   mem_acc_mode_e     w_eff_mode;
   logic              w_request;
   logic              w_reject;
   logic              w_timeout;
   logic              w_acc;
   logic              w_hi;
   logic [7:0]        w_lane_mask;
   logic [63:0]       w_lane_data;
   logic              w_split;
   logic [31:0]       w_load_data;
   logic [31:0]       w_beat_lo;
   logic [31:0]       w_beat_hi;
   logic [ADDR_W-1:0] w_word_addr;

   always_comb begin
      w_mode     = mem_acc_mode_e'(mem_acc_mode);
      w_request  = (rd_en | wr_en) & (mem_acc_mode <= 3'b100);
      // Stores have no unsigned flavour; store also wins over a simultaneous load
      w_eff_mode = w_mode;
      if (wr_en && w_mode == MEM_BU) w_eff_mode = MEM_B;
      if (wr_en && w_mode == MEM_HU) w_eff_mode = MEM_H;
   end

`ifdef MISALIGN_SPLIT_EN
   assign w_reject = 1'b0;
`else
   assign w_reject = misaligned(w_eff_mode, addr[1:0]);
`endif

   assign w_timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign w_acc     = (state_q == ACC0) || (state_q == ACC1);
   assign w_hi      = (state_q == ACC1);
   assign w_beat_lo = w_hi ? beat0_q : bus_rdata;
   assign w_beat_hi = w_hi ? bus_rdata : 32'h0;

   lsu_align u_align (
      .i_mode      (mode_q),
      .i_offset    (addr_q[1:0]),
      .i_wdata     (wdata_q),
      .i_beat_lo   (w_beat_lo),
      .i_beat_hi   (w_beat_hi),
      .o_lane_mask (w_lane_mask),
      .o_lane_data (w_lane_data),
      .o_split     (w_split),
      .o_load_data (w_load_data)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      beat0_d = beat0_q;
      cnt_d   = cnt_q;
      rdata_d = 32'h0;
      merr_d  = 1'b0;
      berr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_request) begin
               mode_d  = w_eff_mode;
               addr_d  = addr;
               wdata_d = wdata;
               we_d    = wr_en;
               cnt_d   = '0;
               if (w_reject) begin
                  state_d = RESP;
                  merr_d  = 1'b1;
               end else begin
                  state_d = ACC0;
               end
            end
         end
         ACC0, ACC1: begin
            if (bus_ack) begin
               cnt_d = '0;
               if (state_q == ACC0 && w_split) begin
                  state_d = ACC1;
                  beat0_d = bus_rdata;
               end else begin
                  state_d = RESP;
                  rdata_d = we_q ? 32'h0 : w_load_data;
               end
            end else if (w_timeout) begin
               state_d = RESP;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MEM_B;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         we_q    <= 1'b0;
         beat0_q <= 32'h0;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         merr_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         beat0_q <= beat0_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         merr_q  <= merr_d;
         berr_q  <= berr_d;
      end
   end

   assign w_word_addr = {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      done         = (state_q == RESP);
      rdata        = rdata_q;
      misalign_err = merr_q;
      bus_err      = berr_q;
      // Gated by rst so an asynchronous reset releases the pipeline immediately
      stall        = w_request & ~done & ~rst;
      bus_req      = w_acc;
      bus_we       = w_acc & we_q;
      bus_addr     = '0;
      bus_be       = 4'b0000;
      bus_wdata    = 32'h0;
      if (w_acc) begin
         bus_addr = w_hi ? (w_word_addr + ADDR_W'(4)) : w_word_addr;
         bus_be   = w_hi ? w_lane_mask[7:4] : w_lane_mask[3:0];
         if (we_q) bus_wdata = w_hi ? w_lane_data[63:32] : w_lane_data[31:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lsu_sequencer : directed vector table plus hand sequences for split,
// timeout, no-access mode and asynchronous reset.
// Revision: 1.0
// ============================================================================
module tb_lsu_sequencer;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  mem_acc_mode = 3'b111;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        stall, done, misalign_err, bus_err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brd;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      logic        e_merr;
   } vec_t;

   vec_t vecs[16];
   int   nvec = 0;

   lsu_sequencer #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .mem_acc_mode (mem_acc_mode),
      .addr         (addr),
      .wdata        (wdata),
      .stall        (stall),
      .done         (done),
      .rdata        (rdata),
      .misalign_err (misalign_err),
      .bus_err      (bus_err),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_be       (bus_be),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input vec_t v);
      vecs[nvec] = v;
      nvec++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      next_cycle();
      rd_en = v.rd; wr_en = v.wr; mem_acc_mode = v.mode; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d_stall_c0", idx), {31'h0, stall}, 32'h1);
      chk($sformatf("v%0d_req_c0", idx), {31'h0, bus_req}, 32'h0);
      next_cycle();
      @(negedge clk);
      if (v.e_merr) begin
         chk($sformatf("v%0d_done", idx), {31'h0, done}, 32'h1);
         chk($sformatf("v%0d_merr", idx), {31'h0, misalign_err}, 32'h1);
         chk($sformatf("v%0d_noreq", idx), {31'h0, bus_req}, 32'h0);
         chk($sformatf("v%0d_rdata", idx), rdata, 32'h0);
         chk($sformatf("v%0d_stall_resp", idx), {31'h0, stall}, 32'h0);
      end else begin
         chk($sformatf("v%0d_req", idx), {31'h0, bus_req}, 32'h1);
         chk($sformatf("v%0d_addr", idx), bus_addr, v.e_addr);
         chk($sformatf("v%0d_be", idx), {28'h0, bus_be}, {28'h0, v.e_be});
         chk($sformatf("v%0d_we", idx), {31'h0, bus_we}, {31'h0, v.e_we});
         if (v.e_we) chk($sformatf("v%0d_wdata", idx), bus_wdata, v.e_wd);
         chk($sformatf("v%0d_stall_c1", idx), {31'h0, stall}, 32'h1);
         bus_ack = 1'b1; bus_rdata = v.brd;
         next_cycle();
         bus_ack = 1'b0; bus_rdata = 32'h0;
         @(negedge clk);
         chk($sformatf("v%0d_done", idx), {31'h0, done}, 32'h1);
         chk($sformatf("v%0d_stall_resp", idx), {31'h0, stall}, 32'h0);
         chk($sformatf("v%0d_req_resp", idx), {31'h0, bus_req}, 32'h0);
         chk($sformatf("v%0d_errs", idx), {30'h0, misalign_err, bus_err}, 32'h0);
         if (!v.e_we) chk($sformatf("v%0d_rdata", idx), rdata, v.e_rd);
      end
      next_cycle();
      rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111;
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", idx), {31'h0, done}, 32'h0);
      chk($sformatf("v%0d_rdata_clr", idx), rdata, 32'h0);
   endtask

   initial begin
      //          rd    wr    mode    addr          wdata         bus_rdata     e_addr        e_be     e_we  e_wdata       e_rdata       e_merr
      add_vec('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0});
      add_vec('{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        32'h0000_0100, 4'b1000, 1'b1, 32'hA500_0000, 32'h0,        1'b0});
      add_vec('{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_0000, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 1'b0});
      add_vec('{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h8001_0000, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        32'h0000_8001, 1'b0});
      add_vec('{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0,        32'h0000_0200, 4'b1100, 1'b1, 32'hBEEF_0000, 32'h0,        1'b0});
      add_vec('{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_8000, 32'h0000_0100, 4'b0010, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0});
      add_vec('{1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'h0000_8000, 32'h0000_0100, 4'b0010, 1'b0, 32'h0,        32'h0000_0080, 1'b0});
      add_vec('{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        32'h0000_0300, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0,        1'b0});
      // Simultaneous rd/wr with BU mode runs as a byte store
      add_vec('{1'b1, 1'b1, 3'b011, 32'h0000_0003, 32'h0000_0077, 32'h0,        32'h0000_0000, 4'b1000, 1'b1, 32'h7700_0000, 32'h0,        1'b0});
      add_vec('{1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,        32'h0BAD_F00D, 32'hFFFF_FFFC, 4'b1111, 1'b0, 32'h0,        32'h0BAD_F00D, 1'b0});
`ifdef MISALIGN_SPLIT_EN
      add_vec('{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h00AB_CD00, 32'h0000_0100, 4'b0110, 1'b0, 32'h0,        32'hFFFF_ABCD, 1'b0});
`else
      add_vec('{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h00AB_CD00, 32'h0000_0100, 4'b0110, 1'b0, 32'h0,        32'h0,        1'b1});
      add_vec('{1'b1, 1'b0, 3'b010, 32'h0000_00FE, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b1});
`endif

      #2;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_bus", {28'h0, bus_req, bus_we, misalign_err, bus_err}, 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_be_rdata", {28'h0, bus_be} | rdata | bus_wdata, 32'h0);
      next_cycle();
      rst = 1'b0;

      for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

`ifdef MISALIGN_SPLIT_EN
      // Word-crossing load split into two beats
      next_cycle();
      rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_00FE;
      next_cycle();
      @(negedge clk);
      chk("split_b0_addr", bus_addr, 32'h0000_00FC);
      chk("split_b0_be", {28'h0, bus_be}, 32'h0000_000C);
      bus_ack = 1'b1; bus_rdata = 32'h5678_0000;
      next_cycle();
      bus_rdata = 32'h0000_1234;
      @(negedge clk);
      chk("split_b1_req", {31'h0, bus_req}, 32'h1);
      chk("split_b1_addr", bus_addr, 32'h0000_0100);
      chk("split_b1_be", {28'h0, bus_be}, 32'h0000_0003);
      chk("split_stall", {31'h0, stall}, 32'h1);
      next_cycle();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
      chk("split_done", {31'h0, done}, 32'h1);
      chk("split_rdata", rdata, 32'h1234_5678);
      next_cycle();
      rd_en = 1'b0; mem_acc_mode = 3'b111;
`endif

      // Mode 111 with rd_en: no access, no stall
      next_cycle();
      rd_en = 1'b1; mem_acc_mode = 3'b111; addr = 32'h0000_0040;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("none_c%0d", c), {29'h0, stall, bus_req, done}, 32'h0);
         next_cycle();
      end
      rd_en = 1'b0;

      // Store timeout: bus_ack never comes
      next_cycle();
      wr_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_0040; wdata = 32'h1111_2222;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         @(negedge clk);
         chk($sformatf("to_req_c%0d", c), {31'h0, bus_req}, 32'h1);
         chk($sformatf("to_done_c%0d", c), {31'h0, done}, 32'h0);
      end
      next_cycle();
      @(negedge clk);
      chk("to_req_drop", {31'h0, bus_req}, 32'h0);
      chk("to_done", {31'h0, done}, 32'h1);
      chk("to_bus_err", {31'h0, bus_err}, 32'h1);
      chk("to_rdata", rdata, 32'h0);
      chk("to_stall", {31'h0, stall}, 32'h0);
      next_cycle();
      wr_en = 1'b0; mem_acc_mode = 3'b111;
      @(negedge clk);
      chk("to_idle", {29'h0, bus_req, done, bus_err}, 32'h0);

      // Asynchronous reset during ACC0
      next_cycle();
      rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h0000_0500;
      next_cycle();
      @(negedge clk);
      chk("ar_req_before", {31'h0, bus_req}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("ar_req_drop", {31'h0, bus_req}, 32'h0);
      chk("ar_stall_drop", {31'h0, stall}, 32'h0);
      chk("ar_addr_drop", bus_addr, 32'h0);
      next_cycle();
      rst = 1'b0; rd_en = 1'b0; mem_acc_mode = 3'b111;
      @(negedge clk);
      chk("ar_idle", {29'h0, bus_req, done, stall}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("ar_idle2", {29'h0, bus_req, done, stall}, 32'h0);
      run_vec(vecs[0], 99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
